// File: rtl/vpu_pkg.sv
// Shared VPU parameters, SRAM address helpers and the operand-fetch state encoding.
package vpu_pkg;
  localparam int unsigned OPERAND_WIDTH       = 32;
  localparam int unsigned VLANE_CNT           = 8;
  localparam int unsigned LANE_W              = OPERAND_WIDTH * VLANE_CNT;
  localparam int unsigned DIM_SIZE            = 1024;
  localparam int unsigned EXEC_CNT            = DIM_SIZE / LANE_W;
  localparam int unsigned EXEC_CNT_LG2        = $clog2(EXEC_CNT);
  localparam int unsigned SRAM_BANK_CNT_LG2   = 2;
  localparam int unsigned SRAM_BANK_DEPTH_LG2 = 8;
  localparam int unsigned ADDR_W              = SRAM_BANK_CNT_LG2 + SRAM_BANK_DEPTH_LG2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RREQ,
    ST_RDATA,
    ST_UNPACK,
    ST_DONE
  } fetch_state_e;

  function automatic logic [SRAM_BANK_CNT_LG2-1:0] get_bank_id(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: SRAM_BANK_CNT_LG2];
  endfunction

  function automatic logic [SRAM_BANK_DEPTH_LG2-1:0] get_waddr(input logic [ADDR_W-1:0] addr);
    return addr[SRAM_BANK_DEPTH_LG2-1:0];
  endfunction
endpackage

// File: rtl/vpu_unpack_buf.sv
// Holds one SRAM word and presents it as EXEC_CNT lane slices over a valid/ready port.
module vpu_unpack_buf
  import vpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic [DIM_SIZE-1:0] data_i,
  output logic                op_valid_o,
  input  logic                op_ready_i,
  output logic [LANE_W-1:0]   op_data_o,
  output logic                op_last_o,
  output logic                done_o
);
  logic [DIM_SIZE-1:0]     buf_q, buf_d;
  logic [EXEC_CNT_LG2-1:0] ptr_q, ptr_d;
  logic                    valid_q, valid_d;
  logic                    is_last;
  logic                    hs;

  assign is_last = (ptr_q == EXEC_CNT_LG2'(EXEC_CNT - 1));
  assign hs      = valid_q & op_ready_i;

  always_comb begin
    buf_d   = buf_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    if (load_i) begin
      buf_d   = data_i;
      ptr_d   = '0;
      valid_d = 1'b1;
    end else if (hs) begin
      // pointer wraps back to 0 after the last slice
      ptr_d = ptr_q + EXEC_CNT_LG2'(1);
      if (is_last) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q   <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
    end
  end

  assign op_valid_o = valid_q;
  assign op_data_o  = buf_q[ptr_q*LANE_W +: LANE_W];
  assign op_last_o  = valid_q & is_last;
  assign done_o     = hs & is_last;
endmodule

// File: rtl/vpu_operand_fetch_unit.sv
// Operand fetch: one SRAM read request per vector, then lane-slice delivery via vpu_unpack_buf.
module vpu_operand_fetch_unit
  import vpu_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           reset_cmd_i,
  input  logic                           fetch_valid_i,
  output logic                           fetch_ready_o,
  input  logic [ADDR_W-1:0]              fetch_addr_i,
  output logic                           rreq_o,
  output logic [SRAM_BANK_CNT_LG2-1:0]   rid_o,
  output logic [SRAM_BANK_DEPTH_LG2-1:0] raddr_o,
  input  logic                           rack_i,
  input  logic                           rvalid_i,
  input  logic                           rlast_i,
  input  logic [DIM_SIZE-1:0]            rdata_i,
  output logic                           op_valid_o,
  input  logic                           op_ready_i,
  output logic [LANE_W-1:0]              op_data_o,
  output logic                           op_last_o,
  output logic                           fetch_done_o
);
  fetch_state_e                   state_q, state_d;
  logic                           rreq_q, rreq_d;
  logic [SRAM_BANK_CNT_LG2-1:0]   rid_q, rid_d;
  logic [SRAM_BANK_DEPTH_LG2-1:0] raddr_q, raddr_d;
  logic                           done_q, done_d;
  logic                           load;
  logic                           slices_done;
  logic                           unused_rlast;

  // single-beat protocol: every beat is the last one
  assign unused_rlast = rlast_i;

  assign load = ((state_q == ST_RREQ) & rack_i & rvalid_i) |
                ((state_q == ST_RDATA) & rvalid_i);

  always_comb begin
    state_d = state_q;
    rreq_d  = rreq_q;
    rid_d   = rid_q;
    raddr_d = raddr_q;
    done_d  = done_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fetch_valid_i) begin
          rreq_d  = 1'b1;
          rid_d   = get_bank_id(fetch_addr_i);
          raddr_d = get_waddr(fetch_addr_i);
          state_d = ST_RREQ;
        end
      end
      ST_RREQ: begin
        if (rack_i) begin
          rreq_d  = 1'b0;
          rid_d   = '0;
          raddr_d = '0;
          state_d = rvalid_i ? ST_UNPACK : ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (rvalid_i) state_d = ST_UNPACK;
      end
      ST_UNPACK: begin
        if (slices_done) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (reset_cmd_i) begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rreq_q  <= 1'b0;
      rid_q   <= '0;
      raddr_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rreq_q  <= rreq_d;
      rid_q   <= rid_d;
      raddr_q <= raddr_d;
      done_q  <= done_d;
    end
  end

  vpu_unpack_buf u_unpack_buf (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .data_i     (rdata_i),
    .op_valid_o (op_valid_o),
    .op_ready_i (op_ready_i),
    .op_data_o  (op_data_o),
    .op_last_o  (op_last_o),
    .done_o     (slices_done)
  );

  assign fetch_ready_o = (state_q == ST_IDLE);
  assign rreq_o        = rreq_q;
  assign rid_o         = rid_q;
  assign raddr_o       = raddr_q;
  assign fetch_done_o  = done_q;
endmodule

// File: tb/tb_vpu_operand_fetch_unit.sv
// Directed bench for vpu_operand_fetch_unit with hand-computed expectations.
module tb_vpu_operand_fetch_unit;
  logic          clk = 1'b0;
  logic          rst;
  logic          reset_cmd_i;
  logic          fetch_valid_i;
  logic          fetch_ready_o;
  logic [9:0]    fetch_addr_i;
  logic          rreq_o;
  logic [1:0]    rid_o;
  logic [7:0]    raddr_o;
  logic          rack_i;
  logic          rvalid_i;
  logic          rlast_i;
  logic [1023:0] rdata_i;
  logic          op_valid_o;
  logic          op_ready_i;
  logic [255:0]  op_data_o;
  logic          op_last_o;
  logic          fetch_done_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vpu_operand_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .reset_cmd_i   (reset_cmd_i),
    .fetch_valid_i (fetch_valid_i),
    .fetch_ready_o (fetch_ready_o),
    .fetch_addr_i  (fetch_addr_i),
    .rreq_o        (rreq_o),
    .rid_o         (rid_o),
    .raddr_o       (raddr_o),
    .rack_i        (rack_i),
    .rvalid_i      (rvalid_i),
    .rlast_i       (rlast_i),
    .rdata_i       (rdata_i),
    .op_valid_o    (op_valid_o),
    .op_ready_i    (op_ready_i),
    .op_data_o     (op_data_o),
    .op_last_o     (op_last_o),
    .fetch_done_o  (fetch_done_o)
  );

  always @(negedge clk) begin
    if (rvalid_i) assert (rlast_i) else $error("protocol error: rvalid_i without rlast_i");
  end

  function automatic logic [255:0] exp_slice(input logic [31:0] base, input int k);
    logic [31:0] w;
    w = base + 32'(k);
    return {8{w}};
  endfunction

  function automatic logic [1023:0] make_rdata(input logic [31:0] base);
    logic [1023:0] d;
    for (int k = 0; k < 4; k++) d[k*256 +: 256] = exp_slice(base, k);
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus-only helpers
  task automatic issue(input logic [9:0] addr);
    fetch_valid_i = 1'b1;
    fetch_addr_i  = addr;
    tick();
    fetch_valid_i = 1'b0;
  endtask

  task automatic ack_then_data(input logic [31:0] base);
    rack_i = 1'b1;
    tick();
    rack_i   = 1'b0;
    rvalid_i = 1'b1;
    rdata_i  = make_rdata(base);
    tick();
    rvalid_i = 1'b0;
  endtask

  task automatic drain_and_release();
    op_ready_i = 1'b1;
    repeat (4) tick();
    op_ready_i  = 1'b0;
    reset_cmd_i = 1'b1;
    tick();
    reset_cmd_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_tests++;
    if ({fetch_ready_o, rreq_o, rid_o, raddr_o, op_valid_o, op_last_o, fetch_done_o} !== {1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ready=%b rreq=%b rid=%0d raddr=%h valid=%b last=%b done=%b, want ready=1 others 0",
               fetch_ready_o, rreq_o, rid_o, raddr_o, op_valid_o, op_last_o, fetch_done_o);
    end
    n_tests++;
    if (op_data_o !== 256'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", op_data_o);
    end
  endtask

  task automatic test_basic();
    issue(10'h2A5);
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if ({rreq_o, rid_o, raddr_o, fetch_ready_o} !== {1'b1, 2'd2, 8'hA5, 1'b0}) begin
        n_fail++;
        $display("FAIL basic_req%0d: got rreq=%b rid=%0d raddr=%h ready=%b want 1 2 a5 0",
                 c, rreq_o, rid_o, raddr_o, fetch_ready_o);
      end
      if (c < 2) tick();
    end
    rack_i = 1'b1;
    tick();
    rack_i = 1'b0;
    n_tests++;
    if ({rreq_o, rid_o, raddr_o, op_valid_o} !== {1'b0, 2'd0, 8'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_ack: got rreq=%b rid=%0d raddr=%h valid=%b want 0 0 00 0", rreq_o, rid_o, raddr_o, op_valid_o);
    end
    rvalid_i = 1'b1;
    rdata_i  = make_rdata(32'hA0);
    tick();
    rvalid_i   = 1'b0;
    op_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if ({op_valid_o, op_last_o, op_data_o} !== {1'b1, (k == 3), exp_slice(32'hA0, k)}) begin
        n_fail++;
        $display("FAIL basic_slice%0d: got valid=%b last=%b data=%h want valid=1 last=%b data=%h",
                 k, op_valid_o, op_last_o, op_data_o, (k == 3), exp_slice(32'hA0, k));
      end
      tick();
    end
    op_ready_i = 1'b0;
    n_tests++;
    if ({fetch_done_o, op_valid_o, fetch_ready_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL basic_done: got done=%b valid=%b ready=%b want 1 0 0", fetch_done_o, op_valid_o, fetch_ready_o);
    end
    reset_cmd_i = 1'b1;
    tick();
    reset_cmd_i = 1'b0;
  endtask

  task automatic test_backpressure();
    logic pat [3] = '{1'b1, 1'b0, 1'b0};
    int hs = 0;
    issue(10'h13C);
    n_tests++;
    if ({rid_o, raddr_o} !== {2'd1, 8'h3C}) begin
      n_fail++;
      $display("FAIL bp_addr: got rid=%0d raddr=%h want 1 3c", rid_o, raddr_o);
    end
    ack_then_data(32'hB0);
    for (int c = 0; c < 20 && hs < 4; c++) begin
      op_ready_i = pat[c % 3];
      n_tests++;
      if ({op_valid_o, op_last_o, op_data_o} !== {1'b1, (hs == 3), exp_slice(32'hB0, hs)}) begin
        n_fail++;
        $display("FAIL bp_cycle%0d: got valid=%b last=%b data=%h want valid=1 last=%b data=%h",
                 c, op_valid_o, op_last_o, op_data_o, (hs == 3), exp_slice(32'hB0, hs));
      end
      if (op_valid_o && op_ready_i) hs++;
      tick();
    end
    op_ready_i = 1'b0;
    n_tests++;
    if (hs != 4 || fetch_done_o !== 1'b1 || op_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_count: got handshakes=%0d done=%b valid=%b want 4 1 0", hs, fetch_done_o, op_valid_o);
    end
    reset_cmd_i = 1'b1;
    tick();
    reset_cmd_i = 1'b0;
  endtask

  task automatic test_same_cycle_ack();
    issue(10'h0FF);
    rack_i   = 1'b1;
    rvalid_i = 1'b1;
    rdata_i  = make_rdata(32'hC0);
    tick();
    rack_i   = 1'b0;
    rvalid_i = 1'b0;
    n_tests++;
    if ({op_valid_o, rreq_o, op_data_o} !== {1'b1, 1'b0, exp_slice(32'hC0, 0)}) begin
      n_fail++;
      $display("FAIL same_cycle: got valid=%b rreq=%b data=%h want 1 0 %h",
               op_valid_o, rreq_o, op_data_o, exp_slice(32'hC0, 0));
    end
    drain_and_release();
  endtask

  task automatic test_release();
    issue(10'h301);
    ack_then_data(32'hD0);
    reset_cmd_i = 1'b1;
    tick();
    reset_cmd_i = 1'b0;
    n_tests++;
    if ({op_valid_o, fetch_ready_o, fetch_done_o, op_data_o} !== {1'b1, 1'b0, 1'b0, exp_slice(32'hD0, 0)}) begin
      n_fail++;
      $display("FAIL release_unpack: got valid=%b ready=%b done=%b data=%h want 1 0 0 %h",
               op_valid_o, fetch_ready_o, fetch_done_o, op_data_o, exp_slice(32'hD0, 0));
    end
    op_ready_i = 1'b1;
    repeat (4) tick();
    op_ready_i = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({fetch_done_o, fetch_ready_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL release_hold: got done=%b ready=%b want 1 0", fetch_done_o, fetch_ready_o);
    end
    reset_cmd_i = 1'b1;
    tick();
    reset_cmd_i = 1'b0;
    n_tests++;
    if ({fetch_done_o, fetch_ready_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL release_done: got done=%b ready=%b want 0 1", fetch_done_o, fetch_ready_o);
    end
  endtask

  task automatic test_mid_reset();
    issue(10'h1C7);
    rack_i = 1'b1;
    tick();
    rack_i = 1'b0;
    rst    = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({fetch_ready_o, rreq_o, rid_o, raddr_o, op_valid_o, op_last_o, fetch_done_o} !== {1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_state: got ready=%b rreq=%b rid=%0d raddr=%h valid=%b last=%b done=%b want ready=1 others 0",
               fetch_ready_o, rreq_o, rid_o, raddr_o, op_valid_o, op_last_o, fetch_done_o);
    end
    rvalid_i = 1'b1;
    rdata_i  = make_rdata(32'hE0);
    tick();
    rvalid_i = 1'b0;
    n_tests++;
    if ({op_valid_o, fetch_ready_o, op_data_o} !== {1'b0, 1'b1, 256'd0}) begin
      n_fail++;
      $display("FAIL midrst_late_rvalid: got valid=%b ready=%b data=%h want 0 1 0", op_valid_o, fetch_ready_o, op_data_o);
    end
  endtask

  task automatic test_illegal_traffic();
    rvalid_i = 1'b1;
    rdata_i  = make_rdata(32'hF0);
    tick();
    rvalid_i = 1'b0;
    n_tests++;
    if ({op_valid_o, rreq_o, op_data_o} !== {1'b0, 1'b0, 256'd0}) begin
      n_fail++;
      $display("FAIL idle_rvalid: got valid=%b rreq=%b data=%h want 0 0 0", op_valid_o, rreq_o, op_data_o);
    end
    issue(10'h055);
    ack_then_data(32'h10);
    fetch_valid_i = 1'b1;
    fetch_addr_i  = 10'h3EE;
    tick();
    n_tests++;
    if ({fetch_ready_o, rreq_o, op_valid_o, op_data_o} !== {1'b0, 1'b0, 1'b1, exp_slice(32'h10, 0)}) begin
      n_fail++;
      $display("FAIL busy_request: got ready=%b rreq=%b valid=%b data=%h want 0 0 1 %h",
               fetch_ready_o, rreq_o, op_valid_o, op_data_o, exp_slice(32'h10, 0));
    end
    op_ready_i = 1'b1;
    repeat (4) tick();
    op_ready_i = 1'b0;
    n_tests++;
    if ({fetch_done_o, fetch_ready_o, rreq_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL busy_done: got done=%b ready=%b rreq=%b want 1 0 0", fetch_done_o, fetch_ready_o, rreq_o);
    end
    reset_cmd_i = 1'b1;
    tick();
    reset_cmd_i = 1'b0;
    tick();
    fetch_valid_i = 1'b0;
    n_tests++;
    if ({rreq_o, rid_o, raddr_o, fetch_ready_o} !== {1'b1, 2'd3, 8'hEE, 1'b0}) begin
      n_fail++;
      $display("FAIL second_request: got rreq=%b rid=%0d raddr=%h ready=%b want 1 3 ee 0",
               rreq_o, rid_o, raddr_o, fetch_ready_o);
    end
    ack_then_data(32'h20);
    drain_and_release();
    n_tests++;
    if (fetch_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL final_idle: got ready=%b want 1", fetch_ready_o);
    end
  endtask

  initial begin
    rst           = 1'b1;
    reset_cmd_i   = 1'b0;
    fetch_valid_i = 1'b0;
    fetch_addr_i  = '0;
    rack_i        = 1'b0;
    rvalid_i      = 1'b0;
    rlast_i       = 1'b1;
    rdata_i       = '0;
    op_ready_i    = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_same_cycle_ack();
    test_release();
    test_mid_reset();
    test_illegal_traffic();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
